// File: rtl/vliw_pkg.sv
// Shared constants, opcodes and types for the ten-slot VLIW core.
// Each slot is one 32-bit instruction; a bundle is ten slots side by side.
package vliw_pkg;

    localparam int unsigned NSLOT      = 10;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned BUNDLE_W   = NSLOT * XLEN;
    localparam int unsigned IMEM_DEPTH = 64;
    localparam int unsigned DMEM_DEPTH = 256;
    localparam int unsigned NREG       = 32;

    // Field positions inside a slot
    localparam int unsigned OP_LSB  = 27;
    localparam int unsigned RD_LSB  = 22;
    localparam int unsigned RS1_LSB = 17;
    localparam int unsigned RS2_LSB = 12;

    localparam logic [4:0] OP_NOP = 5'b00000;
    localparam logic [4:0] OP_ADD = 5'b00101;
    localparam logic [4:0] OP_SUB = 5'b00110;
    localparam logic [4:0] OP_MUL = 5'b00111;
    localparam logic [4:0] OP_AND = 5'b01000;
    localparam logic [4:0] OP_OR  = 5'b01001;
    localparam logic [4:0] OP_XOR = 5'b01010;
    localparam logic [4:0] OP_LI  = 5'b10010;
    localparam logic [4:0] OP_LW  = 5'b10011;
    localparam logic [4:0] OP_SW  = 5'b10100;

    typedef logic [4:0]      reg_idx_t;
    typedef logic [XLEN-1:0] word_t;
    typedef logic [7:0]      dmem_addr_t;

    typedef struct packed {
        logic     we;
        reg_idx_t addr;
        word_t    data;
    } rf_wr_t;

    function automatic word_t alu(input logic [4:0] op, input word_t a, input word_t b);
        word_t r;
        r = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_MUL:  r = a * b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_memory.sv
// 256x32 data memory with one read and one write port per slot.
// Contents survive reset; writes are suppressed while reset is asserted.
module data_memory
    import vliw_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  dmem_addr_t [NSLOT-1:0]      addr_i,
    output word_t      [NSLOT-1:0]      rdata_o,
    input  logic       [NSLOT-1:0]      we_i,
    input  word_t      [NSLOT-1:0]      wdata_i
);

    word_t data_q [DMEM_DEPTH];

    for (genvar k = 0; k < NSLOT; k++) begin : g_read
        assign rdata_o[k] = data_q[addr_i[k]];
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            for (int k = 0; k < NSLOT; k++) begin
                if (we_i[k]) begin
                    data_q[addr_i[k]] <= wdata_i[k];
                end
            end
        end
    end

    task initialize();
        for (int i = 0; i < DMEM_DEPTH; i++) begin
            data_q[i] <= '0;
        end
    endtask

endmodule

// File: rtl/register_file.sv
// 32x32 register file: 20 combinational read ports, 10 write ports.
// When several ports target one register the highest port index wins.
module register_file
    import vliw_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  reg_idx_t [NSLOT-1:0]        raddr_a_i,
    input  reg_idx_t [NSLOT-1:0]        raddr_b_i,
    output word_t    [NSLOT-1:0]        rdata_a_o,
    output word_t    [NSLOT-1:0]        rdata_b_o,
    input  rf_wr_t   [NSLOT-1:0]        wr_i
);

    word_t registerFile [NREG];

    for (genvar k = 0; k < NSLOT; k++) begin : g_read
        assign rdata_a_o[k] = registerFile[raddr_a_i[k]];
        assign rdata_b_o[k] = registerFile[raddr_b_i[k]];
    end

    // Ascending loop: a later slot's assignment overrides an earlier one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREG; i++) begin
                registerFile[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NSLOT; k++) begin
                if (wr_i[k].we) begin
                    registerFile[wr_i[k].addr] <= wr_i[k].data;
                end
            end
        end
    end

    task initialize();
        for (int i = 0; i < NREG; i++) begin
            registerFile[i] <= '0;
        end
    endtask

endmodule

// File: rtl/vliw_processor.sv
// Ten-slot single-cycle VLIW core: fetch, decode, execute and commit in one clock.
// All slots see pre-bundle state; register/memory writes commit together at the edge.
module vliw_processor
    import vliw_pkg::*;
(
    input  logic clk,
    input  logic rst_n
);

    logic [BUNDLE_W-1:0] imem [IMEM_DEPTH];
    logic [7:0]          pc_q;
    logic [7:0]          pc_d;
    logic [BUNDLE_W-1:0] bundle;

    reg_idx_t   [NSLOT-1:0] rf_raddr_a;
    reg_idx_t   [NSLOT-1:0] rf_raddr_b;
    word_t      [NSLOT-1:0] rf_rdata_a;
    word_t      [NSLOT-1:0] rf_rdata_b;
    rf_wr_t     [NSLOT-1:0] rf_wr;
    dmem_addr_t [NSLOT-1:0] dm_addr;
    word_t      [NSLOT-1:0] dm_rdata;
    logic       [NSLOT-1:0] dm_we;
    word_t      [NSLOT-1:0] dm_wdata;

    assign bundle = imem[pc_q[7:2]];
    // 8-bit byte PC wraps 252 -> 0 on its own.
    assign pc_d   = pc_q + 8'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    for (genvar k = 0; k < NSLOT; k++) begin : g_slot
        word_t      slot;
        logic [4:0] op;
        rf_wr_t     wr;
        logic       st;

        assign slot = bundle[k*XLEN +: XLEN];
        assign op   = slot[OP_LSB +: 5];

        // SW sources its store data from the rd field, so port B is steered there.
        assign rf_raddr_a[k] = slot[RS1_LSB +: 5];
        assign rf_raddr_b[k] = (op == OP_SW) ? slot[RD_LSB +: 5] : slot[RS2_LSB +: 5];
        assign dm_addr[k]    = rf_rdata_a[k][7:0] + slot[7:0];
        assign dm_wdata[k]   = rf_rdata_b[k];

        always_comb begin
            wr      = '0;
            wr.addr = slot[RD_LSB +: 5];
            st      = 1'b0;
            case (op)
                OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR: begin
                    wr.we   = 1'b1;
                    wr.data = alu(op, rf_rdata_a[k], rf_rdata_b[k]);
                end
                OP_LI: begin
                    wr.we   = 1'b1;
                    wr.data = {10'd0, slot[21:0]};
                end
                OP_LW: begin
                    wr.we   = 1'b1;
                    wr.data = dm_rdata[k];
                end
                OP_SW: begin
                    st = 1'b1;
                end
                default: begin
                    wr.we = 1'b0;
                end
            endcase
        end

        assign rf_wr[k] = wr;
        assign dm_we[k] = st;
    end

    register_file rf (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .raddr_a_i (rf_raddr_a),
        .raddr_b_i (rf_raddr_b),
        .rdata_a_o (rf_rdata_a),
        .rdata_b_o (rf_rdata_b),
        .wr_i      (rf_wr)
    );

    data_memory mem (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .addr_i  (dm_addr),
        .rdata_o (dm_rdata),
        .we_i    (dm_we),
        .wdata_i (dm_wdata)
    );

    task initPC();
        pc_q <= '0;
    endtask

    task initInst();
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            imem[i] = '0;
        end
    endtask

    task writeInst(input logic [319:0] inst, input logic [31:0] index);
        imem[index[7:2]] = inst;
    endtask

endmodule

// File: tb/tb_vliw_processor.sv
// Scenario bench for vliw_processor: programs are loaded through the top's tasks,
// expected register values are queued at load time and compared after execution.
module tb_vliw_processor;

    logic clk;
    logic rst_n;

    vliw_processor dut (
        .clk   (clk),
        .rst_n (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t         sb[$];
    int           pass_cnt;
    int           total_cnt;
    logic [319:0] bun;

    function automatic logic [31:0] enc_r(logic [4:0] op, int rd, int rs1, int rs2);
        return {op, 5'(rd), 5'(rs1), 5'(rs2), 12'h000};
    endfunction

    function automatic logic [31:0] enc_li(int rd, int imm);
        return {5'b10010, 5'(rd), 22'(imm)};
    endfunction

    function automatic logic [31:0] enc_m(logic [4:0] op, int rd, int rs1, int imm);
        return {op, 5'(rd), 5'(rs1), 17'(imm)};
    endfunction

    task automatic put(input int k, input logic [31:0] w);
        bun[k*32 +: 32] = w;
    endtask

    task automatic commit(input int idx);
        dut.writeInst(bun, 32'(idx * 4));
        bun = '0;
    endtask

    task automatic push(input string name, input int idx, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.idx  = idx;
        e.val  = val;
        sb.push_back(e);
    endtask

    // Hold reset and clear instruction memory so a fresh program can be loaded.
    task automatic start_program();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        dut.initInst();
        bun = '0;
    endtask

    task automatic run(input int n);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int nz;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (dut.pc_q !== 8'd0) $display("FAIL reset_pc: got %0d expected 0", dut.pc_q);
        else pass_cnt++;
        nz = 0;
        for (int i = 0; i < 32; i++) if (dut.rf.registerFile[i] !== 32'd0) nz++;
        total_cnt++;
        if (nz !== 0) $display("FAIL reset_regs: got %0d nonzero expected 0", nz);
        else pass_cnt++;
    endtask

    task automatic test_li_add();
        exp_t e;
        int   nz;
        start_program();
        put(2, enc_li(5, 451));
        commit(0);
        put(2, enc_li(3, 543));
        commit(1);
        put(5, enc_r(5'b00101, 7, 5, 3));
        commit(2);
        push("li_r5", 5, 32'd451);
        push("li_r3", 3, 32'd543);
        push("add_r7", 7, 32'd994);
        run(3);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total_cnt++;
            if (dut.rf.registerFile[e.idx] !== e.val)
                $display("FAIL %s: got %h expected %h", e.name, dut.rf.registerFile[e.idx], e.val);
            else pass_cnt++;
        end
        nz = 0;
        for (int i = 0; i < 32; i++)
            if (i != 3 && i != 5 && i != 7 && dut.rf.registerFile[i] !== 32'd0) nz++;
        total_cnt++;
        if (nz !== 0) $display("FAIL li_add_others: got %0d nonzero expected 0", nz);
        else pass_cnt++;
        total_cnt++;
        if (dut.pc_q !== 8'd12) $display("FAIL li_add_pc: got %0d expected 12", dut.pc_q);
        else pass_cnt++;
    endtask

    task automatic test_stable();
        exp_t e;
        push("stable_r5", 5, 32'd451);
        push("stable_r3", 3, 32'd543);
        push("stable_r7", 7, 32'd994);
        repeat (40) @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total_cnt++;
            if (dut.rf.registerFile[e.idx] !== e.val)
                $display("FAIL %s: got %h expected %h", e.name, dut.rf.registerFile[e.idx], e.val);
            else pass_cnt++;
        end
        total_cnt++;
        if (dut.pc_q !== 8'd172) $display("FAIL stable_pc: got %0d expected 172", dut.pc_q);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (dut.rf.registerFile[7] !== 32'd0)
            $display("FAIL areset_r7: got %h expected 0", dut.rf.registerFile[7]);
        else pass_cnt++;
        total_cnt++;
        if (dut.pc_q !== 8'd0) $display("FAIL areset_pc: got %0d expected 0", dut.pc_q);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (dut.pc_q !== 8'd0) $display("FAIL areset_hold_pc: got %0d expected 0", dut.pc_q);
        else pass_cnt++;
        run(3);
        total_cnt++;
        if (dut.rf.registerFile[7] !== 32'd994)
            $display("FAIL areset_rerun_r7: got %h expected %h", dut.rf.registerFile[7], 32'd994);
        else pass_cnt++;
    endtask

    task automatic test_parallel();
        exp_t e;
        start_program();
        put(0, enc_li(2, 5));
        commit(0);
        put(0, enc_r(5'b00101, 1, 2, 2));
        put(1, enc_li(2, 7));
        commit(1);
        push("par_r1", 1, 32'd10);
        push("par_r2", 2, 32'd7);
        run(2);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total_cnt++;
            if (dut.rf.registerFile[e.idx] !== e.val)
                $display("FAIL %s: got %h expected %h", e.name, dut.rf.registerFile[e.idx], e.val);
            else pass_cnt++;
        end
    endtask

    task automatic test_conflict();
        exp_t e;
        start_program();
        put(3, enc_li(4, 1));
        put(8, enc_li(4, 2));
        commit(0);
        push("conflict_r4", 4, 32'd2);
        run(1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total_cnt++;
            if (dut.rf.registerFile[e.idx] !== e.val)
                $display("FAIL %s: got %h expected %h", e.name, dut.rf.registerFile[e.idx], e.val);
            else pass_cnt++;
        end
    endtask

    task automatic test_memory();
        exp_t e;
        start_program();
        put(0, enc_li(1, 9));
        commit(0);
        put(4, enc_m(5'b10100, 1, 0, 3));
        commit(1);
        put(6, enc_m(5'b10011, 6, 0, 3));
        commit(2);
        // 0x2FE + 5 = 0x303: address truncates to word 3
        put(0, enc_li(9, 32'h2FE));
        commit(3);
        put(9, enc_m(5'b10011, 10, 9, 5));
        commit(4);
        push("lw_r6", 6, 32'd9);
        push("lw_wrap_r10", 10, 32'd9);
        run(5);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total_cnt++;
            if (dut.rf.registerFile[e.idx] !== e.val)
                $display("FAIL %s: got %h expected %h", e.name, dut.rf.registerFile[e.idx], e.val);
            else pass_cnt++;
        end
        total_cnt++;
        if (dut.mem.data_q[3] !== 32'd9)
            $display("FAIL sw_dmem3: got %h expected %h", dut.mem.data_q[3], 32'd9);
        else pass_cnt++;
    endtask

    task automatic test_arith_wrap();
        exp_t e;
        start_program();
        put(0, enc_li(1, 1));
        put(1, enc_li(3, 32'h10000));
        commit(0);
        put(0, enc_r(5'b00110, 2, 0, 1));
        put(1, enc_r(5'b00111, 4, 3, 3));
        commit(1);
        put(2, enc_r(5'b01000, 5, 2, 3));
        put(3, enc_r(5'b01001, 6, 1, 3));
        put(4, enc_r(5'b01010, 7, 2, 1));
        put(9, enc_r(5'b11111, 8, 1, 1));
        commit(2);
        push("sub_r2", 2, 32'hFFFF_FFFF);
        push("mul_r4", 4, 32'h0);
        push("and_r5", 5, 32'h0001_0000);
        push("or_r6", 6, 32'h0001_0001);
        push("xor_r7", 7, 32'hFFFF_FFFE);
        push("nop_r8", 8, 32'h0);
        run(3);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total_cnt++;
            if (dut.rf.registerFile[e.idx] !== e.val)
                $display("FAIL %s: got %h expected %h", e.name, dut.rf.registerFile[e.idx], e.val);
            else pass_cnt++;
        end
        // 61 more bundles bring the PC back to 0 and the program re-runs identically.
        push("wrap_r2", 2, 32'hFFFF_FFFF);
        push("wrap_r7", 7, 32'hFFFF_FFFE);
        repeat (61) @(posedge clk);
        #1;
        total_cnt++;
        if (dut.pc_q !== 8'd0) $display("FAIL pc_wrap: got %0d expected 0", dut.pc_q);
        else pass_cnt++;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total_cnt++;
            if (dut.rf.registerFile[e.idx] !== e.val)
                $display("FAIL %s: got %h expected %h", e.name, dut.rf.registerFile[e.idx], e.val);
            else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        bun       = '0;
        rst_n     = 1'b1;
        test_reset();
        test_li_add();
        test_stable();
        test_async_reset();
        test_parallel();
        test_conflict();
        test_memory();
        test_arith_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
